// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks a pc through a one-cycle-latency instruction
// memory and delivers (pc, inst) pairs through a two-deep buffer (output slot + skid slot).
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module fetch_unit #(
   parameter logic [`WORD_LEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [`WORD_LEN-1:0] imem_addr,
   input  logic [`WORD_LEN-1:0] imem_rdata,
   input  logic                 redirect_valid,
   input  logic [`WORD_LEN-1:0] redirect_pc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [`WORD_LEN-1:0] out_pc,
   output logic [`WORD_LEN-1:0] out_inst
);

   // Handshake: an entry moves to the consumer on a rising edge where out_valid and
   // out_ready are both 1; while out_valid=1 and out_ready=0, out_pc/out_inst hold.
   logic [`WORD_LEN-1:0] pc;
   logic                 inflight;
   logic [`WORD_LEN-1:0] inflight_pc;
   logic                 skid_valid;
   logic [`WORD_LEN-1:0] skid_pc;
   logic [`WORD_LEN-1:0] skid_inst;

   logic       pop;
   logic       issue;
   logic [1:0] occ;
   logic [1:0] occ_after;

   assign pop       = out_valid & out_ready;
   assign occ       = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, inflight};
   assign occ_after = occ - {1'b0, pop};
   // Only issue when the returning word is guaranteed a free slot next cycle.
   assign issue     = !rst && !redirect_valid && (occ_after < 2'd2);
   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= {RESET_PC[`WORD_LEN-1:2], 2'b00};
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         inflight   <= 1'b0;
      end else if (redirect_valid) begin
         pc         <= {redirect_pc[`WORD_LEN-1:2], 2'b00};
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         inflight   <= 1'b0;
      end else begin
         if (issue) begin
            pc          <= pc + 32'd4;
            inflight    <= 1'b1;
            inflight_pc <= pc;
         end else begin
            inflight    <= 1'b0;
         end

         if (pop && skid_valid) begin
            out_valid  <= 1'b1;
            out_pc     <= skid_pc;
            out_inst   <= skid_inst;
            skid_valid <= inflight;
            if (inflight) begin
               skid_pc   <= inflight_pc;
               skid_inst <= imem_rdata;
            end
         end else if (pop || !out_valid) begin
            // Output slot is empty after this edge, and the skid slot is empty too.
            out_valid <= inflight;
            if (inflight) begin
               out_pc   <= inflight_pc;
               out_inst <= imem_rdata;
            end
         end else if (inflight) begin
            skid_valid <= 1'b1;
            skid_pc    <= inflight_pc;
            skid_inst  <= imem_rdata;
         end
      end
   end

endmodule
